// File: rtl/fft_butterfly_sequencer_if.sv
// Handshake bundle between the FFT butterfly sequencer, the sample loader and
// the butterfly datapath / sample RAM.
interface fft_butterfly_sequencer_if #(
  parameter int LOG2N  = 8,
  parameter int ADDR_W = 9
);
  logic              fft_start;
  logic              abort;
  logic              bf_done;
  logic              bf_start;
  logic              mem_we;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [LOG2N-2:0]  tw_idx;
  logic [2:0]        stage_idx;
  logic [LOG2N-2:0]  bfly_idx;
  logic              busy;
  logic              fft_done;

  modport master (
    input  fft_start, abort, bf_done,
    output bf_start, mem_we, addr_a, addr_b, tw_idx, stage_idx, bfly_idx, busy, fft_done
  );

  modport slave (
    output fft_start, abort, bf_done,
    input  bf_start, mem_we, addr_a, addr_b, tw_idx, stage_idx, bfly_idx, busy, fft_done
  );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// Walks every stage/butterfly of an in-place radix-2 DIT FFT, issuing operand
// addresses and twiddle index, handshaking with the butterfly unit and strobing write-back.
module fft_butterfly_sequencer #(
  parameter int LOG2N  = 8,
  parameter int ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     n_rst,
  fft_butterfly_sequencer_if.master bus
);
  localparam int              JW         = LOG2N - 1;
  localparam logic [2:0]      LAST_STAGE = 3'(LOG2N - 1);
  localparam logic [JW-1:0]   LAST_BFLY  = {JW{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [2:0]        stage_r;
  logic [JW-1:0]     bfly_r;
  logic              bf_start_r;
  logic              mem_we_r;
  logic              fft_done_r;
  logic              busy_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic [JW-1:0]     tw_idx_r;

  logic [2:0]        nxt_stage_s;
  logic [JW-1:0]     nxt_bfly_s;
  logic              last_bfly_s;
  logic              last_stage_s;

  function automatic logic [LOG2N-1:0] half_of(input logic [2:0] s);
    return LOG2N'(1) << s;
  endfunction

  // The butterfly index j is split at bit s; a zero is inserted there to form the upper leg.
  function automatic logic [ADDR_W-1:0] calc_addr_a(input logic [2:0] s, input logic [JW-1:0] j);
    logic [LOG2N-1:0] jx;
    logic [LOG2N-1:0] lo;
    jx = {1'b0, j};
    lo = jx & (half_of(s) - LOG2N'(1));
    return ADDR_W'(((jx >> s) << ({1'b0, s} + 4'd1)) | lo);
  endfunction

  function automatic logic [ADDR_W-1:0] calc_addr_b(input logic [2:0] s, input logic [JW-1:0] j);
    return calc_addr_a(s, j) + ADDR_W'(half_of(s));
  endfunction

  function automatic logic [JW-1:0] calc_tw(input logic [2:0] s, input logic [JW-1:0] j);
    logic [LOG2N-1:0] lo;
    lo = {1'b0, j} & (half_of(s) - LOG2N'(1));
    return JW'(lo << (4'(LOG2N - 1) - {1'b0, s}));
  endfunction

  // Next butterfly/stage coordinates after the current write-back.
  always_comb begin
    last_bfly_s  = (bfly_r == LAST_BFLY);
    last_stage_s = (stage_r == LAST_STAGE);
    nxt_bfly_s   = bfly_r + JW'(1);
    if (last_bfly_s) begin
      nxt_stage_s = stage_r + 3'd1;
    end else begin
      nxt_stage_s = stage_r;
    end
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      stage_r    <= 3'd0;
      bfly_r     <= {JW{1'b0}};
      bf_start_r <= 1'b0;
      mem_we_r   <= 1'b0;
      fft_done_r <= 1'b0;
      busy_r     <= 1'b0;
      addr_a_r   <= {ADDR_W{1'b0}};
      addr_b_r   <= {ADDR_W{1'b0}};
      tw_idx_r   <= {JW{1'b0}};
    end else begin
      bf_start_r <= 1'b0;
      mem_we_r   <= 1'b0;
      fft_done_r <= 1'b0;
      if (bus.abort) begin
        state_r  <= IDLE;
        stage_r  <= 3'd0;
        bfly_r   <= {JW{1'b0}};
        busy_r   <= 1'b0;
        addr_a_r <= {ADDR_W{1'b0}};
        addr_b_r <= {ADDR_W{1'b0}};
        tw_idx_r <= {JW{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.fft_start) begin
              state_r    <= ISSUE;
              busy_r     <= 1'b1;
              bf_start_r <= 1'b1;
              stage_r    <= 3'd0;
              bfly_r     <= {JW{1'b0}};
              addr_a_r   <= calc_addr_a(3'd0, {JW{1'b0}});
              addr_b_r   <= calc_addr_b(3'd0, {JW{1'b0}});
              tw_idx_r   <= calc_tw(3'd0, {JW{1'b0}});
            end else begin
              state_r <= IDLE;
            end
          end
          ISSUE: begin
            state_r <= WAIT;
          end
          WAIT: begin
            if (bus.bf_done) begin
              state_r  <= WRITE;
              mem_we_r <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end
          WRITE: begin
            if (last_bfly_s && last_stage_s) begin
              state_r    <= DONE;
              fft_done_r <= 1'b1;
            end else begin
              state_r    <= ISSUE;
              bf_start_r <= 1'b1;
              stage_r    <= nxt_stage_s;
              bfly_r     <= nxt_bfly_s;
              addr_a_r   <= calc_addr_a(nxt_stage_s, nxt_bfly_s);
              addr_b_r   <= calc_addr_b(nxt_stage_s, nxt_bfly_s);
              tw_idx_r   <= calc_tw(nxt_stage_s, nxt_bfly_s);
            end
          end
          DONE: begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            stage_r  <= 3'd0;
            bfly_r   <= {JW{1'b0}};
            addr_a_r <= {ADDR_W{1'b0}};
            addr_b_r <= {ADDR_W{1'b0}};
            tw_idx_r <= {JW{1'b0}};
          end
          default: begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            stage_r  <= 3'd0;
            bfly_r   <= {JW{1'b0}};
            addr_a_r <= {ADDR_W{1'b0}};
            addr_b_r <= {ADDR_W{1'b0}};
            tw_idx_r <= {JW{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.bf_start  = bf_start_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.fft_done  = fft_done_r;
  assign bus.busy      = busy_r;
  assign bus.addr_a    = addr_a_r;
  assign bus.addr_b    = addr_b_r;
  assign bus.tw_idx    = tw_idx_r;
  assign bus.stage_idx = stage_r;
  assign bus.bfly_idx  = bfly_r;
endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Self-checking bench for fft_butterfly_sequencer: a delay-programmable butterfly
// responder, a busy/write-back monitor and an arithmetic address model.
module tb_fft_butterfly_sequencer;
  localparam int LOG2N  = 8;
  localparam int ADDR_W = 9;
  localparam int N      = 1 << LOG2N;
  localparam int HALF_N = N / 2;
  localparam int NBF    = HALF_N * LOG2N;

  logic clk;
  logic n_rst;
  logic inj_done;
  logic resp_done;
  int   resp_k;
  int   resp_cnt;
  int   checks;
  int   errors;
  int   mon_busy_cnt;
  int   mon_we;
  int   mon_done_at;
  logic mon_prev_busy;
  int   obs_a  [NBF];
  int   obs_b  [NBF];
  int   obs_tw [NBF];

  fft_butterfly_sequencer_if #(.LOG2N(LOG2N), .ADDR_W(ADDR_W)) bus ();

  fft_butterfly_sequencer #(.LOG2N(LOG2N), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.bf_done = resp_done | inj_done;

  // Butterfly unit model: result valid resp_k cycles after bf_start.
  always @(negedge clk) begin
    if (!n_rst) begin
      resp_cnt  <= 0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= (resp_cnt == 1);
      if (bus.bf_start === 1'b1) resp_cnt <= resp_k;
      else if (resp_cnt > 0) resp_cnt <= resp_cnt - 1;
    end
  end

  // Counts busy cycles and write-backs of each transform, and the busy cycle of fft_done.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 && mon_prev_busy !== 1'b1) begin
      mon_busy_cnt <= 1;
      mon_we       <= 0;
      mon_done_at  <= -1;
    end else begin
      if (bus.busy === 1'b1) mon_busy_cnt <= mon_busy_cnt + 1;
      if (bus.mem_we === 1'b1) mon_we <= mon_we + 1;
      if (bus.fft_done === 1'b1) mon_done_at <= mon_busy_cnt + 1;
    end
    mon_prev_busy <= bus.busy;
  end

  function automatic int ref_addr_a(input int s, input int j);
    int half;
    half = 1 << s;
    return (j / half) * 2 * half + (j % half);
  endfunction

  function automatic int ref_tw(input int s, input int j);
    int half;
    half = 1 << s;
    return (j % half) * (HALF_N / half);
  endfunction

  // Runs one transform from IDLE, checking every cycle against the model.
  task automatic walk(input int kfix, input int poke_stage, input int abort_stage,
                      input bit inj_issue, output int exp_cyc);
    int k, ea, eb, et, idx;
    exp_cyc = 1;
    k = (kfix > 0) ? kfix : int'($urandom_range(4, 1));
    resp_k = k;
    bus.fft_start = 1'b1;
    @(negedge clk);
    bus.fft_start = 1'b0;
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < HALF_N; j++) begin
        ea  = ref_addr_a(s, j);
        eb  = ea + (1 << s);
        et  = ref_tw(s, j);
        idx = s * HALF_N + j;
        exp_cyc += k + 2;
        obs_a[idx]  = int'(bus.addr_a);
        obs_b[idx]  = int'(bus.addr_b);
        obs_tw[idx] = int'(bus.tw_idx);
        checks++;
        if (bus.bf_start !== 1'b1 || bus.busy !== 1'b1 || bus.mem_we !== 1'b0 ||
            bus.fft_done !== 1'b0 || bus.addr_a !== ADDR_W'(ea) || bus.addr_b !== ADDR_W'(eb) ||
            bus.tw_idx !== 7'(et) || bus.stage_idx !== 3'(s) || bus.bfly_idx !== 7'(j)) begin
          errors++;
          $display("FAIL issue s=%0d j=%0d: got bf_start=%b busy=%b we=%b a=%0d b=%0d tw=%0d st=%0d bf=%0d, expected bf_start=1 busy=1 we=0 a=%0d b=%0d tw=%0d st=%0d bf=%0d",
                   s, j, bus.bf_start, bus.busy, bus.mem_we, bus.addr_a, bus.addr_b, bus.tw_idx,
                   bus.stage_idx, bus.bfly_idx, ea, eb, et, s, j);
          return;
        end
        if (poke_stage == s && j == 0) bus.fft_start = 1'b1;
        if (inj_issue && idx == 0) inj_done = 1'b1;
        for (int w = 1; w <= k; w++) begin
          @(negedge clk);
          bus.fft_start = 1'b0;
          inj_done = 1'b0;
          if (abort_stage == s && j == 0 && w == k) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            checks++;
            if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.fft_done !== 1'b0 ||
                bus.bf_start !== 1'b0 || bus.stage_idx !== 3'd0 || bus.bfly_idx !== 7'd0) begin
              errors++;
              $display("FAIL abort: got busy=%b we=%b done=%b bf_start=%b st=%0d bf=%0d, expected all 0",
                       bus.busy, bus.mem_we, bus.fft_done, bus.bf_start, bus.stage_idx, bus.bfly_idx);
            end
            return;
          end
          checks++;
          if (bus.bf_start !== 1'b0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1 ||
              bus.addr_a !== ADDR_W'(ea) || bus.addr_b !== ADDR_W'(eb) || bus.tw_idx !== 7'(et)) begin
            errors++;
            $display("FAIL wait s=%0d j=%0d w=%0d: got bf_start=%b we=%b busy=%b a=%0d b=%0d tw=%0d, expected 0 0 1 %0d %0d %0d",
                     s, j, w, bus.bf_start, bus.mem_we, bus.busy, bus.addr_a, bus.addr_b, bus.tw_idx, ea, eb, et);
            return;
          end
        end
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.bf_start !== 1'b0 || bus.busy !== 1'b1 ||
            bus.addr_a !== ADDR_W'(ea) || bus.addr_b !== ADDR_W'(eb) || bus.tw_idx !== 7'(et)) begin
          errors++;
          $display("FAIL write s=%0d j=%0d: got we=%b bf_start=%b busy=%b a=%0d b=%0d tw=%0d, expected 1 0 1 %0d %0d %0d",
                   s, j, bus.mem_we, bus.bf_start, bus.busy, bus.addr_a, bus.addr_b, bus.tw_idx, ea, eb, et);
          return;
        end
        k = (kfix > 0) ? kfix : int'($urandom_range(4, 1));
        resp_k = k;
        @(negedge clk);
      end
    end
    checks++;
    if (bus.fft_done !== 1'b1 || bus.busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.bf_start !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got done=%b busy=%b we=%b bf_start=%b, expected 1 1 0 0",
               bus.fft_done, bus.busy, bus.mem_we, bus.bf_start);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.fft_done !== 1'b0 || bus.stage_idx !== 3'd0 || bus.bfly_idx !== 7'd0 ||
        bus.addr_a !== 9'd0 || bus.addr_b !== 9'd0 || bus.tw_idx !== 7'd0) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b st=%0d bf=%0d a=%0d b=%0d tw=%0d, expected all 0",
               bus.busy, bus.fft_done, bus.stage_idx, bus.bfly_idx, bus.addr_a, bus.addr_b, bus.tw_idx);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_start !== 1'b0 || bus.mem_we !== 1'b0 || bus.fft_done !== 1'b0 ||
        bus.addr_a !== 9'd0 || bus.addr_b !== 9'd0 || bus.tw_idx !== 7'd0 ||
        bus.stage_idx !== 3'd0 || bus.bfly_idx !== 7'd0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b bs=%b we=%b done=%b a=%0d b=%0d tw=%0d st=%0d bf=%0d, expected all 0",
               bus.busy, bus.bf_start, bus.mem_we, bus.fft_done, bus.addr_a, bus.addr_b,
               bus.tw_idx, bus.stage_idx, bus.bfly_idx);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b bf_start=%b, expected 0 0", bus.busy, bus.bf_start);
    end
  endtask

  task automatic test_full_transform();
    int exp_cyc;
    walk(1, -1, -1, 1'b0, exp_cyc);
    checks++;
    if (mon_done_at != 3 * HALF_N * LOG2N + 1) begin
      errors++;
      $display("FAIL full_latency: got %0d, expected %0d", mon_done_at, 3 * HALF_N * LOG2N + 1);
    end
    checks++;
    if (mon_we != NBF) begin
      errors++;
      $display("FAIL full_we_count: got %0d, expected %0d", mon_we, NBF);
    end
    checks++;
    if (obs_a[0] != 0 || obs_b[0] != 1 || obs_tw[0] != 0 || obs_a[1] != 2 || obs_b[1] != 3) begin
      errors++;
      $display("FAIL first_bflies: got a0=%0d b0=%0d tw0=%0d a1=%0d b1=%0d, expected 0 1 0 2 3",
               obs_a[0], obs_b[0], obs_tw[0], obs_a[1], obs_b[1]);
    end
  endtask

  task automatic test_addr_spot();
    int idx [3];
    int ea  [3];
    int eb  [3];
    int et  [3];
    idx = '{1 * HALF_N + 1, 2 * HALF_N + 5, 7 * HALF_N + 127};
    ea  = '{1, 9, 127};
    eb  = '{3, 13, 255};
    et  = '{64, 32, 127};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_a[idx[i]] != ea[i] || obs_b[idx[i]] != eb[i] || obs_tw[idx[i]] != et[i]) begin
        errors++;
        $display("FAIL addr_spot%0d: got a=%0d b=%0d tw=%0d, expected a=%0d b=%0d tw=%0d",
                 i, obs_a[idx[i]], obs_b[idx[i]], obs_tw[idx[i]], ea[i], eb[i], et[i]);
      end
    end
  endtask

  task automatic test_delayed_done();
    int exp_cyc;
    walk(5, -1, -1, 1'b1, exp_cyc);
    checks++;
    if (mon_done_at != 7 * NBF + 1 || mon_we != NBF) begin
      errors++;
      $display("FAIL delayed_latency: got done_at=%0d we=%0d, expected %0d %0d", mon_done_at, mon_we, 7 * NBF + 1, NBF);
    end
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.bf_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_bf_done: got busy=%b we=%b bf_start=%b, expected 0 0 0", bus.busy, bus.mem_we, bus.bf_start);
    end
  endtask

  task automatic test_start_while_busy();
    int exp_cyc;
    walk(1, 3, -1, 1'b0, exp_cyc);
    checks++;
    if (mon_done_at != 3 * HALF_N * LOG2N + 1 || mon_we != NBF) begin
      errors++;
      $display("FAIL start_while_busy: got done_at=%0d we=%0d, expected %0d %0d",
               mon_done_at, mon_we, 3 * HALF_N * LOG2N + 1, NBF);
    end
  endtask

  task automatic test_abort();
    int exp_cyc;
    walk(1, -1, 4, 1'b0, exp_cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || mon_we != 4 * HALF_N || mon_done_at != -1) begin
      errors++;
      $display("FAIL abort_aftermath: got busy=%b we=%0d done_at=%0d, expected 0 %0d -1",
               bus.busy, mon_we, mon_done_at, 4 * HALF_N);
    end
    bus.abort = 1'b1;
    bus.fft_start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.fft_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start: got busy=%b bf_start=%b, expected 0 0", bus.busy, bus.bf_start);
    end
    walk(1, -1, -1, 1'b0, exp_cyc);
    checks++;
    if (mon_done_at != 3 * HALF_N * LOG2N + 1) begin
      errors++;
      $display("FAIL restart_latency: got %0d, expected %0d", mon_done_at, 3 * HALF_N * LOG2N + 1);
    end
  endtask

  task automatic test_random_delay();
    int exp_cyc;
    repeat (int'($urandom_range(5, 0))) @(negedge clk);
    walk(0, -1, -1, 1'b0, exp_cyc);
    checks++;
    if (mon_done_at != exp_cyc || mon_we != NBF) begin
      errors++;
      $display("FAIL random_latency: got done_at=%0d we=%0d, expected %0d %0d", mon_done_at, mon_we, exp_cyc, NBF);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    resp_k = 2;
    bus.fft_start = 1'b1;
    @(negedge clk);
    bus.fft_start = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.mem_we === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_write: got no mem_we within 20 cycles, expected one");
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_start !== 1'b0 || bus.mem_we !== 1'b0 || bus.fft_done !== 1'b0 ||
        bus.addr_a !== 9'd0 || bus.addr_b !== 9'd0 || bus.tw_idx !== 7'd0 ||
        bus.stage_idx !== 3'd0 || bus.bfly_idx !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b we=%b a=%0d b=%0d, expected all 0",
               bus.busy, bus.mem_we, bus.addr_a, bus.addr_b);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_start !== 1'b0 || bus.mem_we !== 1'b0 || bus.fft_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_mid_reset: got busy=%b bs=%b we=%b done=%b, expected 0 0 0 0",
               bus.busy, bus.bf_start, bus.mem_we, bus.fft_done);
    end
    bus.fft_start = 1'b1;
    @(negedge clk);
    bus.fft_start = 1'b0;
    checks++;
    if (bus.bf_start !== 1'b1 || bus.busy !== 1'b1 || bus.addr_a !== 9'd0 || bus.addr_b !== 9'd1 ||
        bus.stage_idx !== 3'd0 || bus.bfly_idx !== 7'd0) begin
      errors++;
      $display("FAIL restart_after_reset: got bs=%b busy=%b a=%0d b=%0d st=%0d bf=%0d, expected 1 1 0 1 0 0",
               bus.bf_start, bus.busy, bus.addr_a, bus.addr_b, bus.stage_idx, bus.bfly_idx);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    inj_done      = 1'b0;
    resp_k        = 1;
    bus.fft_start = 1'b0;
    bus.abort     = 1'b0;
    n_rst         = 1'b0;
    test_reset();
    test_full_transform();
    test_addr_spot();
    test_delayed_done();
    test_start_while_busy();
    test_abort();
    test_random_delay();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_sequencer.md
Name: fft_butterfly_sequencer

Overview:
- Sequences the in-place radix-2 DIT FFT over the sample buffer once the Avalon slave has loaded all samples and pulsed fft_start.
- Per butterfly, it generates the two operand addresses and the twiddle index, then handshakes with the butterfly unit and commands write-back.
- Walks all LOG2N stages and pulses fft_done at the end.
- Sits between the slave/loader (fft_start) and the butterfly datapath plus sample RAM.

Parameters:
- LOG2N, 8, log2 of FFT length N (N=256).
- ADDR_W, 9, width of sample-buffer address; butterfly addresses are zero-extended to this width.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- fft_start  in  1  one-cycle start pulse from slave; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- bf_done  in  1  butterfly unit result valid; sampled only in WAIT
- bf_start  out  1  one-cycle pulse launching a butterfly on addr_a/addr_b/tw_idx
- mem_we  out  1  one-cycle write-back strobe for both results
- addr_a  out  ADDR_W  upper-leg address
- addr_b  out  ADDR_W  lower-leg address
- tw_idx  out  LOG2N-1  twiddle ROM index
- stage_idx  out  3  current stage s (0..LOG2N-1)
- bfly_idx  out  LOG2N-1  current butterfly j (0..N/2-1)
- busy  out  1  high in every state except IDLE
- fft_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; stage and butterfly counters are 0.
  - bf_start, mem_we, fft_done and busy are 0; addr_a, addr_b, tw_idx, stage_idx and bfly_idx are 0.
- Address arithmetic, for stage s and butterfly j:
  - half = 1<<s
  - pos = j & (half-1)
  - grp = j >> s
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + half
  - tw_idx = pos << (LOG2N-1-s)
  - All outputs are registered from the counters and stable from ISSUE through WRITE of a butterfly.
- States:
  - IDLE: on fft_start go to ISSUE with s=0, j=0. Otherwise stay.
  - ISSUE: bf_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until bf_done=1, then go to WRITE. bf_done is ignored in every other state, including the ISSUE cycle. No timeout.
  - WRITE: mem_we=1 for one cycle.
    - If j < N/2-1: j++ and go to ISSUE.
    - Else if s < LOG2N-1: j=0, s++, go to ISSUE.
    - Else go to DONE.
  - DONE: fft_done=1 for one cycle, counters clear to 0, go to IDLE.
- Latency:
  - fft_start to first bf_start is 1 cycle.
  - Each butterfly takes 2+k cycles, where k = cycles from bf_start to bf_done (k≥1).
  - Full transform with k=1: 3*(N/2)*LOG2N + 1 cycles after the IDLE exit (3073 for N=256).
- Boundaries:
  - fft_start while busy: ignored, with no restart and no queueing.
  - abort: wins over every other event in the same cycle, including bf_done and fft_start. Next state is IDLE with counters cleared; no mem_we and no fft_done are issued.
  - abort and fft_start together in IDLE: stay in IDLE.
  - Counters never wrap mid-transform; the last butterfly of the last stage goes to DONE.
  - n_rst mid-operation: immediate return to reset values, with no pulses emitted.
  - busy is 1 in ISSUE, WAIT, WRITE and DONE, and 0 in IDLE.

Test Plan:
- Reset, then fft_start with bf_done tied to a 1-cycle echo of bf_start:
  - first butterfly: addr_a=0, addr_b=1, tw_idx=0, stage_idx=0;
  - second butterfly: addr_a=2, addr_b=3;
  - fft_done exactly 3073 cycles after the IDLE exit, and exactly 1024 mem_we pulses.
- Spot-check the address generator:
  - s=1, j=1: addr_a=1, addr_b=3, tw=64.
  - s=2, j=5: addr_a=9, addr_b=13, tw=32.
  - s=7, j=127: addr_a=127, addr_b=255, tw=127; immediately followed by fft_done.
- bf_done delayed by 5 cycles: bf_start is not repeated, WAIT holds, addresses stay stable, and mem_we fires the cycle after bf_done. bf_done pulsed during ISSUE or IDLE has no effect.
- fft_start pulsed at stage 3: no restart, and fft_done occurs at the same cycle as in the unperturbed run.
- abort asserted in WAIT of stage 4 together with bf_done: next cycle is IDLE with busy=0, no mem_we and no fft_done; a new fft_start restarts at s=0, j=0.
- n_rst low during WRITE: all outputs 0 asynchronously; after release the block sits in IDLE until fft_start.
